// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

    // The counter has to reach WIDTH itself (the finish step), hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: operand/accumulator registers, adder, shifter and sign fix-up.
// Signed operation is compiled in only when MULT_SIGNED_EN is defined.
module mult_shift_add_dp #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               is_signed,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic               sgn;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] fixed;

`ifdef MULT_SIGNED_EN
    assign sgn = is_signed;
`else
    // Pin kept for compatibility; signed mode is not built.
    assign sgn = is_signed & 1'b0;
`endif

    // Magnitude of the most-negative value still fits in WIDTH bits unsigned.
    assign a_mag = (sgn && a_in[WIDTH-1]) ? (~a_in + 1'b1) : a_in;
    assign b_mag = (sgn && b_in[WIDTH-1]) ? (~b_in + 1'b1) : b_in;
    assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    assign fixed = neg ? (~acc + 1'b1) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                mcand  <= a_mag;
                mplier <= b_mag;
                acc    <= '0;
                neg    <= sgn & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            end else if (step) begin
                acc    <= {sum, acc[WIDTH-1:1]};
                mplier <= mplier >> 1;
            end
            if (finish) product <= fixed;
        end
    end

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier with start/ready input and valid/ready output handshakes.
// Define MULT_SIGNED_EN to enable two's-complement operation via is_signed.
module seq_mult_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               is_signed,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    mult_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic             finish;

    // WIDTH shift-add steps, then one finish cycle that registers the (sign-fixed) product.
    assign load   = (state == IDLE) && start;
    assign step   = (state == CALC) && (cnt != LAST);
    assign finish = (state == CALC) && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= CALC;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .a_in      (a_in),
        .b_in      (b_in),
        .is_signed (is_signed),
        .product   (out)
    );

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench: cycle-level behavioural model for the 16-bit build plus directed cases,
// and a small WIDTH=4 instance for the narrow-build checks.
module tb_seq_mult_param;

    localparam int W = 16;
`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_ON = 1'b1;
`else
    localparam bit SIGNED_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           is_signed = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] out;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           done;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       in_ready4;
    logic [7:0] out4;
    logic       out_valid4;
    logic       out_ready4 = 1'b1;
    logic       done4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .is_signed(is_signed), .in_ready(in_ready), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .done(done)
    );

    seq_mult_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4),
        .is_signed(1'b0), .in_ready(in_ready4), .out(out4), .out_valid(out_valid4),
        .out_ready(out_ready4), .done(done4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic s);
        longint x;
        longint y;
        x = longint'(a);
        y = longint'(b);
        if (s && SIGNED_ON) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end
        return (2*W)'(x * y);
    endfunction

    // Behavioural model: an accepted operation produces its product W+1 edges later,
    // then holds until the consumer takes it.
    logic           m_busy = 1'b0;
    logic           m_valid = 1'b0;
    logic           m_done = 1'b0;
    int             m_left = 0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_out = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_done  <= 1'b0;
            m_left  <= 0;
            m_out   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_valid) begin
                if (out_ready) m_valid <= 1'b0;
            end else if (m_busy) begin
                if (m_left == 1) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b1;
                    m_done  <= 1'b1;
                    m_out   <= m_prod;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_left <= W + 1;
                m_prod <= ref_prod(a_in, b_in, is_signed);
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready",  64'(in_ready),  64'(!m_busy && !m_valid));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("done",      64'(done),      64'(m_done));
        check("out",       64'(out),       64'(m_out));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input int hold, input logic [2*W-1:0] exp, input string nm);
        int lat;
        int dn;
        lat = 0;
        while (!in_ready && lat < 60) begin tick(); lat++; end
        a_in = a; b_in = b; is_signed = s; start = 1'b1; out_ready = (hold == 0);
        tick();
        start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            start = 1'($urandom_range(0, 1));
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            tick();
            lat++;
        end
        start = 1'b0;
        check({nm, "_latency"}, 64'(lat), 64'(W + 1));
        check({nm, "_out"}, 64'(out), 64'(exp));
        dn = int'(done);
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            a_in  = W'($urandom);
            tick();
            check({nm, "_held"}, 64'(out), 64'(exp));
            dn += int'(done);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        check({nm, "_done_count"}, 64'(dn), 64'd1);
        check({nm, "_in_ready_back"}, 64'(in_ready), 64'd1);
        check({nm, "_out_kept"}, 64'(out), 64'(exp));
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        #1 rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_out", 64'(out), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        check("model_pin_ffff", 64'(ref_prod(16'hFFFF, 16'hFFFF, 1'b0)), 64'hFFFE_0001);
        check("model_pin_7x9", 64'(ref_prod(16'd7, 16'd9, 1'b0)), 64'd63);

        op(16'd7, 16'd9, 1'b0, 0, 32'd63, "7x9");
        op(16'hFFFF, 16'hFFFF, 1'b0, 5, 32'hFFFE_0001, "max");
`ifdef MULT_SIGNED_EN
        op(16'hFFFD, 16'd5, 1'b1, 0, 32'hFFFF_FFF1, "neg3x5");
        op(16'h8000, 16'h8000, 1'b1, 2, 32'h4000_0000, "minxmin");
`else
        op(16'hFFFD, 16'd5, 1'b1, 0, 32'h0004_FFF1, "unsigned_fffd");
`endif

        // Reset asserted asynchronously during the 8th CALC cycle.
        a_in = 16'd100; b_in = 16'd200; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #1 rst = 1'b1;
        #1;
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_out", 64'(out), 64'd0);
        tick();
        rst = 1'b0;
        op(16'd2, 16'd3, 1'b0, 0, 32'd6, "2x3");

        // Back-to-back with start held high.
        a_in = 16'd11; b_in = 16'd13; is_signed = 1'b0; start = 1'b1; out_ready = 1'b1;
        tick();
        a_in = 16'd0; b_in = 16'hABCD;
        lat = 0;
        while (!out_valid && lat < 60) begin tick(); lat++; end
        check("b2b_first_latency", 64'(lat), 64'(W + 1));
        check("b2b_first_out", 64'(out), 64'd143);
        tick();
        check("b2b_idle_after_xfer", 64'(in_ready), 64'd1);
        tick();
        check("b2b_second_accepted", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 60) begin tick(); lat++; end
        start = 1'b0;
        check("b2b_zero_latency", 64'(lat), 64'(W + 1));
        check("b2b_zero_out", 64'(out), 64'd0);
        tick();
        out_ready = 1'b0;

        // Randomised traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       a_in = 16'h8000;
                1:       a_in = 16'hFFFF;
                2:       a_in = 16'h0000;
                default: a_in = W'($urandom);
            endcase
            b_in      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            is_signed = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) tick();

        // Narrow build.
        a4 = 4'd15; b4 = 4'd15; start4 = 1'b1; out_ready4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 30) begin tick(); lat++; end
        check("w4_15x15_latency", 64'(lat), 64'd5);
        check("w4_15x15_out", 64'(out4), 64'd225);
        check("w4_done", 64'(done4), 64'd1);
        tick();
        a4 = 4'd0; b4 = 4'd15; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 30) begin tick(); lat++; end
        check("w4_0x15_latency", 64'(lat), 64'd5);
        check("w4_0x15_out", 64'(out4), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
